// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense scheduler.
//   state_t          : scheduler FSM states
//   SLOT0..3, HOPPER : actuator target codes driven on act_id
//   DEF_TIMEOUT      : default max act_en-high cycles waiting for act_done
//   DEF_GAP_CYC      : default mechanical dead-time after each actuation
//   slot_id()        : maps a 2-bit product select onto its actuator code
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACT   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [2:0] SLOT0  = 3'd0;
  localparam logic [2:0] SLOT1  = 3'd1;
  localparam logic [2:0] SLOT2  = 3'd2;
  localparam logic [2:0] SLOT3  = 3'd3;
  localparam logic [2:0] HOPPER = 3'd4;

  localparam int DEF_TIMEOUT = 200;
  localparam int DEF_GAP_CYC = 4;

  function automatic logic [2:0] slot_id(input logic [1:0] sel);
    case (sel)
      2'd0:    return SLOT0;
      2'd1:    return SLOT1;
      2'd2:    return SLOT2;
      default: return SLOT3;
    endcase
  endfunction

endpackage

// File: rtl/vend_tmr.sv
// Loadable down-counter shared by the ACT timeout and the GAP dead-time.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val (has priority over en)
//   load_val  : value to load
//   en        : decrement by one, holding at zero
//   zero      : counter currently at zero
module vend_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vend_dispense_sched.sv
// Arbitrates product-dispense and coin-payout requests onto one shared
// actuator, sequences actuations with mechanical dead-time and guards each
// actuation with a timeout that parks the block in FAULT.
//   clk, rst             : clock, asynchronous active-low reset
//   vend_req / vend_sel  : product request and slot (0..3)
//   chg_req / chg_amt    : payout request and coin count (0..15)
//   act_done             : actuator acknowledge for one actuation
//   fault_clr            : leave FAULT
//   vend_gnt / chg_gnt   : one-cycle acceptance pulses
//   vend_done / chg_done : one-cycle completion pulses
//   act_en / act_id      : actuator drive and target (0..3 slot, 4 hopper)
//   busy / fault         : not IDLE / in FAULT
// Every output is a register loaded from the next-state logic.
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] vend_sel,
  input  logic       chg_req,
  input  logic [3:0] chg_amt,
  input  logic       act_done,
  input  logic       fault_clr,
  output logic       vend_gnt,
  output logic       chg_gnt,
  output logic       vend_done,
  output logic       chg_done,
  output logic       act_en,
  output logic [2:0] act_id,
  output logic       busy,
  output logic       fault
);

  // Timer loads are one less than the cycle count because the loaded
  // cycle itself is the first counted cycle.
  localparam logic [7:0] TO_LOAD  = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

  state_t     state, state_nxt;
  logic       arm;         // low for the first cycle after reset release
  logic       rr_chg;      // payout has priority on the next contention
  logic       active_chg;  // operation in progress belongs to the payout side
  logic [3:0] rem;         // actuations still to perform

  logic       rr_chg_nxt, active_chg_nxt;
  logic [3:0] rem_nxt;
  logic [2:0] act_id_nxt;
  logic       vend_gnt_nxt, chg_gnt_nxt, vend_done_nxt, chg_done_nxt;
  logic       act_en_nxt, busy_nxt, fault_nxt;
  logic       contend, pick_vend;
  logic       tmr_load, tmr_en, tmr_zero;
  logic [7:0] tmr_val;

  vend_tmr #(.W(8)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt      = state;
    rr_chg_nxt     = rr_chg;
    active_chg_nxt = active_chg;
    rem_nxt        = rem;
    act_id_nxt     = act_id;
    vend_gnt_nxt   = 1'b0;
    chg_gnt_nxt    = 1'b0;
    vend_done_nxt  = 1'b0;
    chg_done_nxt   = 1'b0;
    tmr_load       = 1'b0;
    tmr_val        = TO_LOAD;
    tmr_en         = 1'b0;
    contend        = vend_req && chg_req;
    pick_vend      = vend_req && (!chg_req || !rr_chg);

    case (state)
      ST_IDLE: begin
        // A zero-coin payout stays in IDLE with chg_gnt high while the
        // requester is still holding chg_req; skip that cycle so the same
        // request is not accepted twice.
        if (arm && !chg_gnt) begin
          if (pick_vend) begin
            vend_gnt_nxt   = 1'b1;
            active_chg_nxt = 1'b0;
            rem_nxt        = 4'd1;
            act_id_nxt     = slot_id(vend_sel);
            state_nxt      = ST_ACT;
            tmr_load       = 1'b1;
            // Priority flips only when both sides actually competed.
            if (contend) rr_chg_nxt = 1'b1;
          end else if (chg_req) begin
            chg_gnt_nxt = 1'b1;
            if (contend) rr_chg_nxt = 1'b0;
            if (chg_amt == 4'd0) begin
              chg_done_nxt = 1'b1;
            end else begin
              active_chg_nxt = 1'b1;
              rem_nxt        = chg_amt;
              act_id_nxt     = HOPPER;
              state_nxt      = ST_ACT;
              tmr_load       = 1'b1;
            end
          end
        end
      end

      ST_ACT: begin
        // act_done wins over a timeout expiring in the same cycle.
        if (act_done) begin
          rem_nxt   = rem - 4'd1;
          state_nxt = ST_GAP;
          tmr_load  = 1'b1;
          tmr_val   = GAP_LOAD;
          if (rem == 4'd1) begin
            if (active_chg) chg_done_nxt  = 1'b1;
            else            vend_done_nxt = 1'b1;
          end
        end else if (tmr_zero) begin
          state_nxt  = ST_FAULT;
          rem_nxt    = 4'd0;
          act_id_nxt = 3'd0;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_zero) begin
          if (rem != 4'd0) begin
            state_nxt = ST_ACT;
            tmr_load  = 1'b1;
          end else begin
            state_nxt  = ST_IDLE;
            act_id_nxt = 3'd0;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        if (fault_clr) state_nxt = ST_IDLE;
      end
    endcase

    act_en_nxt = (state_nxt == ST_ACT);
    busy_nxt   = (state_nxt != ST_IDLE);
    fault_nxt  = (state_nxt == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      arm        <= 1'b0;
      rr_chg     <= 1'b0;
      active_chg <= 1'b0;
      rem        <= 4'd0;
      vend_gnt   <= 1'b0;
      chg_gnt    <= 1'b0;
      vend_done  <= 1'b0;
      chg_done   <= 1'b0;
      act_en     <= 1'b0;
      act_id     <= 3'd0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      arm        <= 1'b1;
      rr_chg     <= rr_chg_nxt;
      active_chg <= active_chg_nxt;
      rem        <= rem_nxt;
      vend_gnt   <= vend_gnt_nxt;
      chg_gnt    <= chg_gnt_nxt;
      vend_done  <= vend_done_nxt;
      chg_done   <= chg_done_nxt;
      act_en     <= act_en_nxt;
      act_id     <= act_id_nxt;
      busy       <= busy_nxt;
      fault      <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_vend_dispense_sched.sv
module tb_vend_dispense_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend_req = 1'b0;
  logic [1:0] vend_sel = 2'd0;
  logic       chg_req = 1'b0;
  logic [3:0] chg_amt = 4'd0;
  logic       act_done = 1'b0;
  logic       fault_clr = 1'b0;
  logic       vend_gnt, chg_gnt, vend_done, chg_done, act_en, busy, fault;
  logic [2:0] act_id;

  vend_dispense_sched dut (
    .clk       (clk),
    .rst       (rst),
    .vend_req  (vend_req),
    .vend_sel  (vend_sel),
    .chg_req   (chg_req),
    .chg_amt   (chg_amt),
    .act_done  (act_done),
    .fault_clr (fault_clr),
    .vend_gnt  (vend_gnt),
    .chg_gnt   (chg_gnt),
    .vend_done (vend_done),
    .chg_done  (chg_done),
    .act_en    (act_en),
    .act_id    (act_id),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  localparam int K_PULSE   = 1;  // act_en fell: a=act_id, b=pulse length
  localparam int K_REACT   = 2;  // act_en rose inside one op: a=low cycles, b=act_id
  localparam int K_VGNT    = 3;  // a=act_id, b=act_en
  localparam int K_CGNT    = 4;  // a=chg_done, b=act_en
  localparam int K_VDONE   = 5;  // a=act_en
  localparam int K_CDONE   = 6;  // a=act_en
  localparam int K_BUSYOFF = 7;  // a=cycles since act_en fell
  localparam int K_FAULT   = 8;  // a=act_en, b=busy

  typedef struct packed {
    logic [3:0] k;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  lat     = 1;   // actuator answers on this act_en cycle; 0 = never
  int  n_rise  = 0;

  function automatic string kname(input int k);
    case (k)
      K_PULSE:   return "pulse";
      K_REACT:   return "react";
      K_VGNT:    return "vend_gnt";
      K_CGNT:    return "chg_gnt";
      K_VDONE:   return "vend_done";
      K_CDONE:   return "chg_done";
      K_BUSYOFF: return "busy_off";
      K_FAULT:   return "fault";
      default:   return "none";
    endcase
  endfunction

  task automatic push(input int k, input int a, input int b);
    ev_t e;
    e.k = 4'(k);
    e.a = 8'(a);
    e.b = 8'(b);
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int a, input int b);
    ev_t g, e;
    g.k = 4'(k);
    g.a = 8'(a);
    g.b = 8'(b);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event %s: got a=%0d b=%0d at %0t, expected no event", kname(k), a, b, $time);
    end else begin
      e = exp_q.pop_front();
      if (g !== e)  begin
        n_fail++;
        $display("FAIL event %s: got a=%0d b=%0d at %0t, expected %s a=%0d b=%0d",
                 kname(k), a, b, $time, kname(int'(e.k)), e.a, e.b);
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req_vend(input logic [1:0] sel);
    bit ok = 0;
    vend_req = 1'b1;
    vend_sel = sel;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (vend_gnt) begin ok = 1; break; end
    end
    if (!ok) check("vend_gnt_timeout", 0, 1);
    vend_req = 1'b0;
    vend_sel = ~sel;   // changes after grant must not matter
  endtask

  task automatic req_chg(input logic [3:0] amt);
    bit ok = 0;
    chg_req = 1'b1;
    chg_amt = amt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (chg_gnt) begin ok = 1; break; end
    end
    if (!ok) check("chg_gnt_timeout", 0, 1);
    chg_req = 1'b0;
    chg_amt = 4'hF;
  endtask

  // Actuator model: acknowledges on the lat-th cycle of each act_en pulse.
  initial begin
    logic prev_m;
    int   mcnt;
    prev_m = 1'b0;
    mcnt   = 0;
    forever begin
      @(negedge clk);
      if (!act_en) begin
        mcnt     = 0;
        act_done = 1'b0;
      end else begin
        if (!prev_m) n_rise++;
        mcnt++;
        act_done = (lat != 0) && (mcnt == lat);
      end
      prev_m = act_en;
    end
  end

  // Monitor: turns output activity into events and checks them in order.
  initial begin
    logic prev_en, prev_busy, prev_fault, held, rise, fall;
    int   since, plen, pid;
    prev_en = 0; prev_busy = 0; prev_fault = 0; held = 0;
    since = 0; plen = 0; pid = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_en = 0; prev_busy = 0; prev_fault = 0; held = 0;
        since = 0; plen = 0; pid = 0;
      end else begin
        rise = act_en && !prev_en;
        fall = !act_en && prev_en;
        if (fall)                 got(K_PULSE, pid, plen);
        if (rise && held)         got(K_REACT, since, int'(act_id));
        if (vend_gnt)             got(K_VGNT, int'(act_id), int'(act_en));
        if (chg_gnt)              got(K_CGNT, int'(chg_done), int'(act_en));
        if (vend_done)            got(K_VDONE, int'(act_en), 0);
        if (chg_done)             got(K_CDONE, int'(act_en), 0);
        if (!busy && prev_busy)   got(K_BUSYOFF, since, 0);
        if (fault && !prev_fault) got(K_FAULT, int'(act_en), int'(busy));
        if (rise) begin
          plen = 1;
          pid  = int'(act_id);
        end else if (act_en && plen < 255) begin
          plen++;
        end
        if (fall) begin
          since = 1;
          held  = busy;
        end else if (!act_en) begin
          if (since < 255) since++;
          if (!busy) held = 0;
        end
        prev_en    = act_en;
        prev_busy  = busy;
        prev_fault = fault;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int r0;

    // Reset state, with a product request already waiting.
    vend_req = 1'b1;
    vend_sel = 2'd2;
    #1 rst = 1'b0;
    #1;
    check("rst_act_en", act_en, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_act_id", act_id, 0);
    check("rst_gnt", {vend_gnt, chg_gnt, vend_done, chg_done}, 0);

    // Single product dispense, slot 2, acknowledged on the 3rd cycle.
    lat = 3;
    push(K_VGNT, 2, 1);
    push(K_PULSE, 2, 3);
    push(K_VDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    #20 rst = 1'b1;             // released at t=22, between edges
    @(posedge clk); #1;
    check("arm_delay_gnt", vend_gnt, 0);
    @(posedge clk); #1;
    check("first_arb_gnt", vend_gnt, 1);
    vend_req = 1'b0;
    vend_sel = 2'd1;
    settle(14);

    // Three-coin payout: three hopper pulses, four low cycles between.
    lat = 2;
    push(K_CGNT, 0, 1);
    push(K_PULSE, 4, 2);
    push(K_REACT, 4, 4);
    push(K_PULSE, 4, 2);
    push(K_REACT, 4, 4);
    push(K_PULSE, 4, 2);
    push(K_CDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    req_chg(4'd3);
    settle(25);

    // Contention: product first, then payout.
    lat = 1;
    push(K_VGNT, 1, 1);
    push(K_PULSE, 1, 1);
    push(K_VDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    push(K_CGNT, 0, 1);
    push(K_PULSE, 4, 1);
    push(K_CDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    fork
      req_vend(2'd1);
      req_chg(4'd1);
    join
    settle(12);

    // Contention again: payout now goes first.
    push(K_CGNT, 0, 1);
    push(K_PULSE, 4, 1);
    push(K_CDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    push(K_VGNT, 3, 1);
    push(K_PULSE, 3, 1);
    push(K_VDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    fork
      req_vend(2'd3);
      req_chg(4'd1);
    join
    settle(12);

    // Acknowledge on the very cycle the timeout expires: still a success.
    lat = 200;
    push(K_VGNT, 0, 1);
    push(K_PULSE, 0, 200);
    push(K_VDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    req_vend(2'd0);
    settle(215);

    // No acknowledge: timeout after 200 cycles, FAULT, no done.
    lat = 0;
    push(K_VGNT, 0, 1);
    push(K_PULSE, 0, 200);
    push(K_FAULT, 0, 1);
    req_vend(2'd0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (fault) begin seen = 1; break; end
    end
    check("fault_seen", seen, 1);
    // A request held through FAULT is served only after fault_clr.
    lat = 2;
    push(K_BUSYOFF, 4, 0);
    push(K_VGNT, 1, 1);
    push(K_PULSE, 1, 2);
    push(K_VDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    vend_req = 1'b1;
    vend_sel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check("fault_hold", fault, 1);
    check("fault_no_gnt", vend_gnt, 0);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    check("fault_clr_busy", busy, 0);
    check("fault_clr_fault", fault, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (vend_gnt) begin seen = 1; break; end
    end
    check("post_fault_gnt", seen, 1);
    vend_req = 1'b0;
    settle(12);

    // Zero-coin payout: grant and done together, no actuation.
    push(K_CGNT, 1, 0);
    push(K_CDONE, 0, 0);
    req_chg(4'd0);
    settle(6);
    check("zero_amt_act_en", act_en, 0);

    // Reset in the middle of the third actuation of a five-coin payout.
    lat = 2;
    push(K_CGNT, 0, 1);
    push(K_PULSE, 4, 2);
    push(K_REACT, 4, 4);
    push(K_PULSE, 4, 2);
    push(K_REACT, 4, 4);
    r0 = n_rise;
    req_chg(4'd5);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (n_rise == r0 + 3) begin seen = 1; break; end
    end
    check("third_act_seen", seen, 1);
    check("mid_act_en", act_en, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_act_en", act_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_act_id", act_id, 0);
    check("rst_mid_done", chg_done, 0);
    @(negedge clk);
    #3 rst = 1'b1;

    // Normal operation after the mid-operation reset.
    lat = 1;
    push(K_VGNT, 3, 1);
    push(K_PULSE, 3, 1);
    push(K_VDONE, 0, 0);
    push(K_BUSYOFF, 4, 0);
    req_vend(2'd3);
    settle(12);

    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispense_sched.md
VEND_DISPENSE_SCHED -- requirements
Module: vend_dispense_sched

Interface
REQ-001 Parameter TIMEOUT, default 200, meaning max cycles act_en may stay high waiting for act_done (range 2..255).
REQ-002 Parameter GAP_CYC, default 4, meaning mechanical dead-time cycles after every actuation (range 1..15).
REQ-003 clk  in  1  single clock, all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 vend_req  in  1  product requester asks for one dispense; held high until vend_gnt.
REQ-006 vend_sel  in  2  product slot 0..3, valid while vend_req high.
REQ-007 chg_req  in  1  change requester asks for a coin payout; held high until chg_gnt.
REQ-008 chg_amt  in  4  coins to pay out (0..15), valid while chg_req high.
REQ-009 act_done  in  1  mechanism acknowledge, one actuation complete.
REQ-010 fault_clr  in  1  leaves FAULT state.
REQ-011 vend_gnt / chg_gnt  out  1 each  one-cycle request acceptance pulses.
REQ-012 vend_done / chg_done  out  1 each  one-cycle completion pulses.
REQ-013 act_en  out  1  drive the shared actuator.
REQ-014 act_id  out  3  actuator target: 0..3 product slot, 4 coin hopper.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 fault  out  1  high while in FAULT.

Function
REQ-017 States SHALL be IDLE, ACT, GAP, FAULT; all outputs registered.
REQ-018 In IDLE, a request sampled high at an edge SHALL produce, on the next cycle, its gnt pulse, latched sel/amt, state ACT, act_en=1, act_id set.
REQ-019 Both requests high in IDLE: grant the requester not served last (round-robin); after reset product wins first.
REQ-020 chg_req with chg_amt=0: chg_gnt and chg_done SHALL pulse in the same cycle, no actuation, state stays IDLE.
REQ-021 In ACT, act_done high SHALL drop act_en next cycle, decrement the remaining count (product count=1), and enter GAP.
REQ-022 The done pulse of the active requester SHALL assert in the cycle act_en drops after its final actuation.
REQ-023 GAP SHALL last exactly GAP_CYC cycles, then ACT if coins remain, else IDLE; IDLE re-arbitrates next edge.
REQ-024 act_en SHALL never be high for more than TIMEOUT consecutive cycles; on expiry go to FAULT, act_en=0, no done pulse, remaining work discarded.
REQ-025 act_done in the same cycle as timeout expiry SHALL count as success.
REQ-026 act_done in IDLE, GAP or FAULT SHALL be ignored.
REQ-027 In FAULT no grants SHALL issue; fault_clr high SHALL return to IDLE next cycle; pending requests then arbitrate normally.
REQ-028 Inputs vend_sel/chg_amt changing after gnt SHALL not affect the operation in progress.

Reset
REQ-029 rst low SHALL immediately force IDLE, all outputs 0, counters 0, round-robin pointer to "product next", regardless of state (including mid-ACT).
REQ-030 First arbitration after rst release SHALL occur on the second rising edge after deassertion.

Structure
REQ-031 State encoding, act_id constants (SLOT0..3, HOPPER=4) and default TIMEOUT/GAP_CYC SHALL live in shared package vend_pkg.
REQ-032 The timeout/gap down-counter SHALL be one sub-module, vend_tmr (load, enable, zero flag).

Verification
REQ-033 Reset, vend_req sel=2, act_done 3 cycles after act_en -> vend_gnt pulse, act_id=2, act_en 3 cycles, vend_done once, busy clears after GAP_CYC.
REQ-034 chg_req amt=3, act_done 2 cycles after each act_en -> exactly 3 act_en pulses id=4 separated by GAP_CYC=4 low cycles, chg_done after third.
REQ-035 vend_req and chg_req(amt=1) same edge, both held -> vend served first, then chg; repeat both -> chg served first.
REQ-036 vend_req, act_done never asserted -> act_en drops after 200 cycles, fault=1, no vend_done; fault_clr -> IDLE, busy=0.
REQ-037 chg_amt=0 -> chg_gnt and chg_done same cycle, act_en stays 0; rst low mid-ACT of amt=5 -> act_en 0 immediately, no done pulse.
